// File: rtl/demod_acq_sequencer.sv
// Per-shot acquisition sequencer: arm, trigger edge, delay, integration window, dump strobe, holdoff.
// Repeats for the programmed shot count (0 = free-run until abort); all outputs are registered.
module demod_acq_sequencer #(
  parameter int CNT_W  = 16,
  parameter int SHOT_W = 16,
  parameter int MISS_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_trigger,
  input  logic [CNT_W-1:0]  i_delay_cycles,
  input  logic [CNT_W-1:0]  i_window_cycles,
  input  logic [CNT_W-1:0]  i_holdoff_cycles,
  input  logic [SHOT_W-1:0] i_num_shots,
  output logic              o_integrate_en,
  output logic              o_dump,
  output logic [SHOT_W-1:0] o_shot_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic [MISS_W-1:0] o_missed_trig,
  output logic [2:0]        o_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_INTEG   = 3'd3;
  localparam logic [2:0] S_DUMP    = 3'd4;
  localparam logic [2:0] S_HOLDOFF = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  logic [2:0]        r_state;
  logic              r_trig_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_delay;
  logic [CNT_W-1:0]  r_window;
  logic [CNT_W-1:0]  r_holdoff;
  logic [SHOT_W-1:0] r_num;
  logic [SHOT_W-1:0] r_shot_idx;
  logic [MISS_W-1:0] r_missed;
  logic              r_integ;
  logic              r_dump;
  logic              r_busy;
  logic              r_done;

  logic              w_edge;
  logic              w_last_shot;
  logic [2:0]        w_next_state;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_arm_ok;
  logic              w_miss;
  logic              w_shot_end;
  logic              w_shot_inc;

  assign w_edge      = i_trigger & ~r_trig_q;
  assign w_last_shot = (r_num != '0) && (r_shot_idx == (r_num - SHOT_ONE));
  assign w_shot_inc  = w_shot_end & ~w_last_shot;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_arm_ok     = 1'b0;
    w_miss       = 1'b0;
    w_shot_end   = 1'b0;
    if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            w_next_state = S_ARMED;
            w_arm_ok     = 1'b1;
          end
        end
        S_ARMED: begin
          if (w_edge) begin
            if (r_delay != '0) begin
              w_next_state = S_DELAY;
              w_next_cnt   = r_delay - CNT_ONE;
            end else begin
              w_next_state = S_INTEG;
              w_next_cnt   = r_window - CNT_ONE;
            end
          end
        end
        S_DELAY: begin
          w_miss = w_edge;
          if (r_cnt == '0) begin
            w_next_state = S_INTEG;
            w_next_cnt   = r_window - CNT_ONE;
          end else begin
            w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        S_INTEG: begin
          w_miss = w_edge;
          if (r_cnt == '0) begin
            w_next_state = S_DUMP;
          end else begin
            w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        S_DUMP: begin
          w_miss = w_edge;
          if (r_holdoff != '0) begin
            w_next_state = S_HOLDOFF;
            w_next_cnt   = r_holdoff - CNT_ONE;
          end else begin
            w_shot_end = 1'b1;
          end
        end
        S_HOLDOFF: begin
          w_miss = w_edge;
          if (r_cnt == '0) begin
            w_shot_end = 1'b1;
          end else begin
            w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
      if (w_shot_end) begin
        w_next_state = w_last_shot ? S_DONE : S_ARMED;
      end
    end
  end

  // trig_q resets high so a trigger already asserted through reset is not seen as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_trig_q   <= 1'b1;
      r_cnt      <= '0;
      r_delay    <= '0;
      r_window   <= '0;
      r_holdoff  <= '0;
      r_num      <= '0;
      r_shot_idx <= '0;
      r_missed   <= '0;
      r_integ    <= 1'b0;
      r_dump     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_trig_q <= i_trigger;
      r_cnt    <= w_next_cnt;
      r_integ  <= (w_next_state == S_INTEG);
      r_dump   <= (w_next_state == S_DUMP);
      r_busy   <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      r_done   <= (w_next_state == S_DONE);
      if (w_arm_ok) begin
        r_delay    <= i_delay_cycles;
        r_window   <= (i_window_cycles == '0) ? CNT_ONE : i_window_cycles;
        r_holdoff  <= i_holdoff_cycles;
        r_num      <= i_num_shots;
        r_shot_idx <= '0;
        r_missed   <= '0;
      end else begin
        if (w_shot_inc) begin
          r_shot_idx <= r_shot_idx + SHOT_ONE;
        end
        if (w_miss && (r_missed != '1)) begin
          r_missed <= r_missed + MISS_ONE;
        end
      end
    end
  end

  assign o_state        = r_state;
  assign o_integrate_en = r_integ;
  assign o_dump         = r_dump;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_shot_idx     = r_shot_idx;
  assign o_missed_trig  = r_missed;

endmodule
